// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// Optional macro SEL_GUARD_EN inserts a one-cycle no-grant GUARD state on every source switch.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic switched
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G0    = 2'd1,
    G1    = 2'd2
`ifdef SEL_GUARD_EN
    ,GUARD = 2'd3
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             last;
  logic             nxt_sel;
  logic             entering;
  state_t           hop0, hop1;

  // Destination when handing the path over to the other source
`ifdef SEL_GUARD_EN
  assign hop0 = GUARD;
  assign hop1 = GUARD;
`else
  assign hop0 = G0;
  assign hop1 = G1;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1)  nxt = last ? G0 : G1;
        else if (req0)     nxt = G0;
        else if (req1)     nxt = G1;
      end
      G0: begin
        // Release takes priority over the forced switch
        if (!req0)                           nxt = req1 ? hop1 : IDLE;
        else if (req1 && hold_cnt == CNT_MAX) nxt = hop1;
      end
      G1: begin
        if (!req1)                           nxt = req0 ? hop0 : IDLE;
        else if (req0 && hold_cnt == CNT_MAX) nxt = hop0;
      end
`ifdef SEL_GUARD_EN
      GUARD: begin
        // sel still names the outgoing source; the target is the other one
        if (sel ? req0 : req1) nxt = sel ? G0 : G1;
        else                   nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    nxt_sel = sel;
    if (nxt == G0)      nxt_sel = 1'b0;
    else if (nxt == G1) nxt_sel = 1'b1;
  end

  assign entering = (nxt != state) && ((nxt == G0) || (nxt == G1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      sel      <= 1'b0;
      switched <= 1'b0;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state    <= nxt;
      gnt0     <= (nxt == G0);
      gnt1     <= (nxt == G1);
      sel      <= nxt_sel;
      switched <= (nxt_sel != sel);
      if (entering) begin
        hold_cnt <= '0;
        last     <= (nxt == G1);
      end else if ((nxt == state) && ((state == G0) || (state == G1)) && (hold_cnt != CNT_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
